// File: rtl/mem_request_queue.sv
// mem_request_queue: DEPTH-entry circular FIFO between the trace parser and the DRAM command
// scheduler. Each non-NOP {opcode, address} from the parser is enqueued. The oldest entry is
// presented over a valid/ready handshake together with its age in cycles since enqueue.
// Optional feature: define QUEUE_STATS_EN to add the hwm (high-water mark of count) output.
// Contains global_defs, the shared opcode/address definitions, so this file stands on its own.

package global_defs;
  parameter int ADDRESS_WIDTH = 32;
  typedef enum logic [1:0] {NOP = 2'd0, READ = 2'd1, WRITE = 2'd2, PREFETCH = 2'd3} parsed_op_t;
endpackage

module mem_request_queue
  import global_defs::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AGE_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  parsed_op_t                 in_opcode,
  input  logic [ADDRESS_WIDTH-1:0]   in_address,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output parsed_op_t                 out_opcode,
  output logic [ADDRESS_WIDTH-1:0]   out_address,
  output logic [AGE_W-1:0]           out_age,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
`ifdef QUEUE_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]     hwm
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [AGE_W-1:0] AgeMax = '1;

  typedef enum logic [1:0] {StEmpty, StActive, StFull} occ_state_e;

  occ_state_e                  state_q;
  logic [PtrW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]             count_q, count_d;
  logic                        overflow_q;
  logic                        push, pop;

  parsed_op_t                  op_mem   [DEPTH];
  logic [ADDRESS_WIDTH-1:0]    addr_mem [DEPTH];
  logic [AGE_W-1:0]            age_q    [DEPTH];
  logic [PtrW-1:0]             slot_off [DEPTH];
  logic [DEPTH-1:0]            occupied;

  // Handshake qualifiers; in_ready depends on registered state only, so a pop cannot free a slot
  // for a push in the same cycle.
  always_comb begin
    push    = (in_opcode != NOP) && (state_q != StFull);
    pop     = (state_q != StEmpty) && out_ready;
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // A slot is occupied when its distance from the head (mod DEPTH) is below the occupancy.
  always_comb begin
    occupied = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_off[i] = PtrW'(i) - rd_ptr_q;
      occupied[i] = ({1'b0, slot_off[i]} < count_q);
    end
  end

  // Pointers, occupancy count, occupancy FSM and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StEmpty;
      overflow_q <= 1'b0;
    end else begin
      if ((in_opcode != NOP) && (state_q == StFull)) overflow_q <= 1'b1;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        state_q  <= StEmpty;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_d;
        unique case (state_q)
          StEmpty:  if (push) state_q <= StActive;
          StActive: begin
            if (count_d == CntW'(DEPTH)) state_q <= StFull;
            else if (count_d == '0)      state_q <= StEmpty;
          end
          StFull:   if (pop) state_q <= StActive;
          default:  state_q <= StEmpty;
        endcase
      end
    end
  end

  // Per-entry age: cleared on enqueue, otherwise saturating increment while occupied.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rst || flush) begin
        age_q[i] <= '0;
      end else if (push && (wr_ptr_q == PtrW'(i))) begin
        age_q[i] <= '0;
      end else if (occupied[i] && (age_q[i] != AgeMax)) begin
        age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  // Payload storage; unreset because the outputs are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      op_mem[wr_ptr_q]   <= in_opcode;
      addr_mem[wr_ptr_q] <= in_address;
    end
  end

`ifdef QUEUE_STATS_EN
  logic [CntW-1:0] hwm_q;

  // High-water mark of the next count; flush drives next count to 0 so it never lowers hwm.
  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= '0;
    end else if (!flush && (count_d > hwm_q)) begin
      hwm_q <= count_d;
    end
  end

  assign hwm = hwm_q;
`endif

  // Head presentation and status flags, all from registered state.
  always_comb begin
    empty       = (state_q == StEmpty);
    full        = (state_q == StFull);
    in_ready    = !full;
    out_valid   = !empty;
    count       = count_q;
    overflow    = overflow_q;
    out_opcode  = empty ? NOP : op_mem[rd_ptr_q];
    out_address = empty ? '0  : addr_mem[rd_ptr_q];
    out_age     = empty ? '0  : age_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_mem_request_queue.sv
// Scoreboard bench for mem_request_queue: stimulus pushes expected requests into a queue,
// a negedge monitor pops and compares whenever the DUT hands off its head entry.
module tb_mem_request_queue;
  import global_defs::*;

  localparam int DEPTH = 16;
  localparam int AGE_W = 8;

  typedef struct packed {
    parsed_op_t               op;
    logic [ADDRESS_WIDTH-1:0] addr;
  } req_t;

  logic                     clk = 1'b0;
  logic                     rst, flush, out_ready;
  parsed_op_t               in_opcode, out_opcode;
  logic [ADDRESS_WIDTH-1:0] in_address, out_address;
  logic                     in_ready, out_valid, full, empty, overflow;
  logic [AGE_W-1:0]         out_age;
  logic [$clog2(DEPTH):0]   count;
`ifdef QUEUE_STATS_EN
  logic [$clog2(DEPTH):0]   hwm;
`endif

  req_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_request_queue #(.DEPTH(DEPTH), .AGE_W(AGE_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_opcode   (in_opcode),
    .in_address  (in_address),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_address (out_address),
    .out_age     (out_age),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow)
`ifdef QUEUE_STATS_EN
    ,
    .hwm         (hwm)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle parser pulse; acc says whether the queue should accept it.
  task automatic drive(input parsed_op_t op, input logic [ADDRESS_WIDTH-1:0] a, input bit acc);
    req_t r;
    r.op   = op;
    r.addr = a;
    in_opcode  = op;
    in_address = a;
    if (acc) exp_q.push_back(r);
    tick();
    in_opcode  = NOP;
    in_address = '0;
  endtask

  // Monitor: every accepted head entry must match the oldest expected request.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got %0h@0x%0h, required no pop", out_opcode, out_address);
      end else begin
        req_t e;
        e = exp_q.pop_front();
        chk("pop_opcode", 64'(out_opcode), 64'(e.op));
        chk("pop_address", 64'(out_address), 64'(e.addr));
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_opcode = NOP; in_address = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_opcode", 64'(out_opcode), 64'(NOP));
    chk("rst_out_address", 64'(out_address), 64'd0);
    chk("rst_out_age", 64'(out_age), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);

    // Single push visible next cycle
    drive(READ, 'h1F0, 1'b1);
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_opcode", 64'(out_opcode), 64'(READ));
    chk("t1_out_address", 64'(out_address), 64'h1F0);
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_out_age", 64'(out_age), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_empty_after_pop", 64'(empty), 64'd1);

    // Fill to DEPTH, then one more is refused and flagged
    for (int i = 0; i < DEPTH; i++)
      drive((i % 2 == 0) ? READ : WRITE, ADDRESS_WIDTH'(i * 'h10 + 'h1000), 1'b1);
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_in_ready", 64'(in_ready), 64'd0);
    chk("t2_count", 64'(count), 64'd16);
    chk("t2_overflow_pre", 64'(overflow), 64'd0);
    drive(WRITE, 'h40, 1'b0);
    chk("t2_overflow", 64'(overflow), 64'd1);
    chk("t2_count_hold", 64'(count), 64'd16);

    // Full: push+pop in the same cycle pops only
    out_ready = 1'b1;
    drive(WRITE, 'h80, 1'b0);
    out_ready = 1'b0;
    chk("t3_count", 64'(count), 64'd15);
    chk("t3_in_ready", 64'(in_ready), 64'd1);
    chk("t3_full", 64'(full), 64'd0);
    out_ready = 1'b1;
    repeat (15) tick();
    chk("t3_empty", 64'(empty), 64'd1);
    chk("t3_count_zero", 64'(count), 64'd0);
    chk("t3_sb_drained", 64'(exp_q.size()), 64'd0);
    // Empty queue ignores out_ready
    repeat (3) tick();
    out_ready = 1'b0;
    chk("t3_empty_ignore", 64'(count), 64'd0);
    chk("t3_empty_valid", 64'(out_valid), 64'd0);

    // Age saturation
    drive(READ, 'h123, 1'b1);
    chk("t4_age0", 64'(out_age), 64'd0);
    repeat (10) tick();
    chk("t4_age10", 64'(out_age), 64'd10);
    repeat (244) tick();
    chk("t4_age254", 64'(out_age), 64'd254);
    tick();
    chk("t4_age255", 64'(out_age), 64'd255);
    repeat (45) tick();
    chk("t4_age_sat", 64'(out_age), 64'd255);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_empty", 64'(empty), 64'd1);

    // Flush beats a concurrent push and keeps overflow
    drive(READ, 'h100, 1'b1);
    drive(WRITE, 'h200, 1'b1);
    drive(READ, 'h300, 1'b1);
    chk("t5_count3", 64'(count), 64'd3);
    flush = 1'b1;
    drive(WRITE, 'h400, 1'b0);
    flush = 1'b0;
    exp_q.delete();
    chk("t5_empty", 64'(empty), 64'd1);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_out_opcode", 64'(out_opcode), 64'(NOP));
    chk("t5_out_address", 64'(out_address), 64'd0);
    chk("t5_overflow_kept", 64'(overflow), 64'd1);
    drive(WRITE, 'h500, 1'b1);
    chk("t5_head_after_flush", 64'(out_address), 64'h500);
    repeat (3) tick();
    chk("t5_age3", 64'(out_age), 64'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-stream discards entries and clears overflow
    drive(READ, 'h600, 1'b1);
    drive(READ, 'h700, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("t6_rst_empty", 64'(empty), 64'd1);
    chk("t6_rst_overflow", 64'(overflow), 64'd0);
`ifdef QUEUE_STATS_EN
    chk("t6_hwm_rst0", 64'(hwm), 64'd0);
`endif

    // Five pushes, then push+pop while active keeps count
    for (int i = 0; i < 5; i++)
      drive((i % 2 == 0) ? WRITE : READ, ADDRESS_WIDTH'('h1000 + i * 8), 1'b1);
    chk("t6_count5", 64'(count), 64'd5);
    out_ready = 1'b1;
    drive(READ, 'h2000, 1'b1);
    out_ready = 1'b0;
    chk("t6_pushpop_count", 64'(count), 64'd5);
    chk("t6_pushpop_head", 64'(out_address), 64'h1008);
    out_ready = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;
    chk("t6_drained", 64'(empty), 64'd1);
`ifdef QUEUE_STATS_EN
    chk("t6_hwm5", 64'(hwm), 64'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_hwm_flush", 64'(hwm), 64'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_hwm_after_rst", 64'(hwm), 64'd0);
`endif

    tick();
    chk("final_sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
